regfile_ctrl: RTL and testbench

REGFILE_CTRL -- requirements
Module: regfile_ctrl

---
 rtl/regfile_ctrl_pkg.sv | 14 +
 rtl/regfile_ctrl_instr_dec.sv | 28 ++
 rtl/regfile_ctrl.sv | 123 ++++++++++++
 tb/tb_regfile_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared state encoding, opcode/op constants and write-back select codes
package regfile_ctrl_pkg;
    typedef enum logic [2:0] {
        WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_IMM, WRITE_REG
    } state_t;
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
endpackage

// File: rtl/regfile_ctrl_instr_dec.sv
// instr_dec: splits the instruction register into fields and sign-extends the immediates
//   ir      in  16  instruction register
//   opcode  out 3   IR[15:13]
//   op      out 2   IR[12:11]
//   rn/rd/rm out 3  register indices IR[10:8] / IR[7:5] / IR[2:0]
//   shift   out 2   IR[4:3]
//   sximm8  out 16  IR[7:0] sign-extended
//   sximm5  out 16  IR[4:0] sign-extended
module instr_dec (
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];
    assign shift  = ir[4:3];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: Moore controller sequencing register-file reads, ALU execute and write-back
//   clk, rst_n            clock, asynchronous active-low reset
//   s, load, in           start strobe, IR load enable, instruction word (all sampled only in WAIT)
//   w                     idle/ready flag
//   readnum, writenum     register-file read/write index
//   write                 register-file write enable
//   loada/b/c/s           datapath load enables
//   asel, bsel, vsel      operand and write-back source selects
//   shift, ALUop          shifter/ALU controls straight from IR
//   sximm8, sximm5        sign-extended immediates from IR
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);
    state_t      state, state_nxt;
    logic [15:0] ir;
    logic [2:0]  opcode, rn, rd, rm;
    logic        mov_imm, mov_reg, mvn, alu, cmp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (load && state == WAIT) ir <= in;
        end
    end

    instr_dec u_dec (
        .ir     (ir),
        .opcode (opcode),
        .op     (ALUop),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .shift  (shift),
        .sximm8 (sximm8),
        .sximm5 (sximm5)
    );

    assign mov_imm = opcode == OPC_MOV && ALUop == OP_MOV_IMM;
    assign mov_reg = opcode == OPC_MOV && ALUop == OP_MOV_REG;
    assign mvn     = opcode == OPC_ALU && ALUop == OP_MVN;
    // ADD, CMP and AND are the two-operand ALU forms
    assign alu     = opcode == OPC_ALU && ALUop != OP_MVN;
    assign cmp     = opcode == OPC_ALU && ALUop == OP_CMP;

    always_comb begin
        state_nxt = state;
        w         = 1'b0;
        readnum   = '0;
        writenum  = '0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = VSEL_C;
        unique case (state)
            WAIT: begin
                w         = 1'b1;
                state_nxt = s ? DECODE : WAIT;
            end
            DECODE:
                state_nxt = mov_imm ? WRITE_IMM :
                            (mov_reg || mvn) ? GET_B :
                            alu ? GET_A : WAIT;
            GET_A: begin
                readnum   = rn;
                loada     = 1'b1;
                state_nxt = GET_B;
            end
            GET_B: begin
                readnum   = rm;
                loadb     = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                // single-operand forms pass B through by zeroing A
                asel      = mov_reg || mvn;
                loads     = cmp;
                loadc     = !cmp;
                state_nxt = cmp ? WAIT : WRITE_REG;
            end
            WRITE_IMM: begin
                writenum  = rn;
                vsel      = VSEL_IMM8;
                write     = 1'b1;
                state_nxt = WAIT;
            end
            WRITE_REG: begin
                writenum  = rd;
                vsel      = VSEL_C;
                write     = 1'b1;
                state_nxt = WAIT;
            end
            default: state_nxt = WAIT;
        endcase
    end
endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: directed and randomized checks of regfile_ctrl against a micro-op sequence model
module tb_regfile_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, s, load;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] ir_m;

    typedef struct packed {
        logic       w;
        logic [2:0] rn;
        logic [2:0] wn;
        logic       wr, la, lb, lc, ls, as, bs;
        logic [1:0] vs;
    } ctl_t;

    regfile_ctrl dut (
        .clk(clk), .rst_n(rst_n), .s(s), .load(load), .in(in),
        .w(w), .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    wire [51:0] obs = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                       asel, bsel, vsel, shift, ALUop, sximm8, sximm5};

    function automatic ctl_t idle_c();
        ctl_t c = '0;
        c.w = 1'b1;
        return c;
    endfunction

    function automatic logic [51:0] pack_exp(ctl_t c, logic [15:0] ir);
        logic [15:0] x8 = {{8{ir[7]}}, ir[7:0]};
        logic [15:0] x5 = {{11{ir[4]}}, ir[4:0]};
        return {c, ir[4:3], ir[12:11], x8, x5};
    endfunction

    function automatic logic [15:0] rand_instr();
        int k = $urandom_range(0, 6);
        logic [10:0] r = 11'($urandom);
        case (k)
            0: return {3'b110, 2'b10, r};
            1: return {3'b110, 2'b00, r};
            2: return {3'b101, 2'b11, r};
            3: return {3'b101, 2'b00, r};
            4: return {3'b101, 2'b01, r};
            5: return {3'b101, 2'b10, r};
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [51:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle controls from DECODE back to WAIT, derived from the instruction's class
    task automatic build(input logic [15:0] ir, output ctl_t q[$]);
        ctl_t c;
        logic [2:0] opc = ir[15:13];
        logic [1:0] op = ir[12:11];
        bit movi = opc == 3'b110 && op == 2'b10;
        bit movr = opc == 3'b110 && op == 2'b00;
        bit mvn  = opc == 3'b101 && op == 2'b11;
        bit alu  = opc == 3'b101 && op != 2'b11;
        bit cmp  = opc == 3'b101 && op == 2'b01;
        q = {};
        q.push_back('0);
        if (movi) begin
            c = '0; c.wn = ir[10:8]; c.wr = 1; c.vs = 2'b10; q.push_back(c);
        end else if (movr || mvn || alu) begin
            if (alu) begin
                c = '0; c.rn = ir[10:8]; c.la = 1; q.push_back(c);
            end
            c = '0; c.rn = ir[2:0]; c.lb = 1; q.push_back(c);
            c = '0; c.as = movr || mvn; c.ls = cmp; c.lc = !cmp; q.push_back(c);
            if (!cmp) begin
                c = '0; c.wn = ir[7:5]; c.wr = 1; c.vs = 2'b00; q.push_back(c);
            end
        end
        q.push_back(idle_c());
    endtask

    // Entered and left at a falling edge with the DUT in WAIT
    task automatic run(input logic [15:0] instr, input bit same_edge, input string tag);
        ctl_t q[$];
        int wr_exp = 0;
        int wr_obs = 0;
        in = instr;
        load = 1'b1;
        s = same_edge;
        if (!same_edge) begin
            @(posedge clk);
            ir_m = instr;
            @(negedge clk);
            check({tag, "/wait"}, pack_exp(idle_c(), ir_m));
            load = 1'b0;
            s = 1'b1;
        end
        @(posedge clk);
        ir_m = instr;
        @(negedge clk);
        s = 1'b0;
        load = 1'b0;
        build(ir_m, q);
        for (int i = 0; i < q.size(); i++) begin
            check($sformatf("%s/step%0d", tag, i), pack_exp(q[i], ir_m));
            wr_obs += int'(write);
            wr_exp += int'(q[i].wr);
            if (i == q.size() - 1) break;
            load = 1'($urandom);
            in = 16'($urandom);
            s = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        load = 1'b0;
        s = 1'b0;
        n_cmp++;
        assert (wr_obs == wr_exp) else begin
            n_bad++;
            $error("FAIL %s/writes: observed %0d expected %0d", tag, wr_obs, wr_exp);
        end
    endtask

    initial begin
        ctl_t c;
        rst_n = 1'b0;
        s = 1'b0;
        load = 1'b0;
        in = 16'hFFFF;
        ir_m = '0;
        #12;
        check("reset", pack_exp(idle_c(), ir_m));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_wait", pack_exp(idle_c(), ir_m));

        run(16'hD007, 0, "movi_r0");
        run(16'hD1F8, 0, "movi_neg");
        run(16'hA148, 0, "add");
        run(16'hA801, 0, "cmp");
        run(16'h0000, 0, "illegal0");
        run(16'hE0FF, 0, "illegal_opc");
        run(16'hC800, 0, "illegal_op");
        run(16'hB8E3, 0, "mvn");
        run(16'hC0B5, 0, "movr");
        run(16'hB35A, 1, "and_same_edge");

        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_hold", pack_exp(idle_c(), ir_m));
        end

        repeat (40) run(rand_instr(), 1'($urandom), "rnd");

        in = 16'hA148;
        load = 1'b1;
        @(posedge clk);
        ir_m = 16'hA148;
        @(negedge clk);
        load = 1'b0;
        s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        c = '0; c.rn = 3'd0; c.lb = 1'b1;
        check("abort/get_b", pack_exp(c, ir_m));
        #2 rst_n = 1'b0;
        #1;
        ir_m = '0;
        check("abort/async", pack_exp(idle_c(), ir_m));
        @(posedge clk);
        @(negedge clk);
        check("abort/held", pack_exp(idle_c(), ir_m));
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort/first_edge", pack_exp(idle_c(), ir_m));
        run(16'hD3FF, 0, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
